ex_muldiv_seq: RTL and testbench

Iterative multiply/divide sequencer for the RV32M instructions, placed beside the EX-stage ALU. It accepts already-forwarded operands from the EX operand muxes and runs a 32-iteration shift-add multiply or restoring divide. While it works it holds the pipeline through a stall output that is OR-ed into the EX-stage stall. When finished it presents a single-cycle result, which the EX result mux selects in place of the ALU result.

---
 rtl/ex_muldiv_seq.sv | 214 +++++++++++++++++++++
 tb/tb_ex_muldiv_seq.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_seq.sv
// ex_muldiv_seq: iterative RV32M multiply/divide sequencer beside the EX ALU.
// Runs a 32-step shift-add multiply or restoring divide and stalls EX while busy.
// Ports:
//   clk, rst            core clock, asynchronous active-high reset
//   md_start, md_op     M instruction valid in EX and its funct3 code
//   md_rs1, md_rs2      forwarded operands, sampled on the issue edge
//   md_kill             pipeline flush, aborts any operation in progress
//   md_stall            hold request into the EX stall (combinational from md_start)
//   md_done             one-cycle result-valid pulse
//   md_result           registered result, held until the next done
//   md_busy             high while iterating
module ex_muldiv_seq #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            md_start,
    input  logic [2:0]      md_op,
    input  logic [XLEN-1:0] md_rs1,
    input  logic [XLEN-1:0] md_rs2,
    input  logic            md_kill,
    output logic            md_stall,
    output logic            md_done,
    output logic [XLEN-1:0] md_result,
    output logic            md_busy
);

    localparam int unsigned CNT_W = $clog2(XLEN);
    localparam int unsigned DW    = 2 * XLEN;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0]  ALL_ONES = {XLEN{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic             neg_q, neg_d;
    logic [XLEN-1:0]  hi_q, hi_d;       // mul: accumulator, div: partial remainder
    logic [XLEN-1:0]  lo_q, lo_d;       // mul: multiplier/product low, div: dividend/quotient
    logic [XLEN-1:0]  opb_q, opb_d;     // multiplicand or divisor magnitude
    logic [XLEN-1:0]  result_q, result_d;

    // Issue decode on the incoming operands
    logic            issue_c;
    logic            a_signed_c, b_signed_c, a_neg_c, b_neg_c;
    logic            div_zero_c, div_ovf_c;
    logic [XLEN-1:0] mag_a_c, mag_b_c;

    always_comb begin
        issue_c    = (state_q == S_IDLE) && md_start && !md_kill;
        a_signed_c = (md_op == OP_MUL) || (md_op == OP_MULH) || (md_op == OP_MULHSU) ||
                     (md_op == OP_DIV) || (md_op == OP_REM);
        b_signed_c = (md_op == OP_MUL) || (md_op == OP_MULH) ||
                     (md_op == OP_DIV) || (md_op == OP_REM);
        a_neg_c    = a_signed_c && md_rs1[XLEN-1];
        b_neg_c    = b_signed_c && md_rs2[XLEN-1];
        mag_a_c    = a_neg_c ? (XLEN'(0) - md_rs1) : md_rs1;
        mag_b_c    = b_neg_c ? (XLEN'(0) - md_rs2) : md_rs2;
        div_zero_c = md_op[2] && (md_rs2 == '0);
        div_ovf_c  = ((md_op == OP_DIV) || (md_op == OP_REM)) &&
                     (md_rs1 == INT_MIN) && (md_rs2 == ALL_ONES);
    end

    // One iteration step of each algorithm plus the final sign-corrected result
    logic [XLEN:0]   mul_sum_c;
    logic [XLEN-1:0] mul_hi_c, mul_lo_c;
    logic [XLEN:0]   rem_sh_c, div_diff_c;
    logic            div_ge_c;
    logic [XLEN-1:0] div_hi_c, div_lo_c;
    logic [DW-1:0]   prod_c;
    logic [XLEN-1:0] div_sel_c, div_res_c, calc_res_c;

    always_comb begin
        mul_sum_c  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
        mul_hi_c   = mul_sum_c[XLEN:1];
        mul_lo_c   = {mul_sum_c[0], lo_q[XLEN-1:1]};

        // Partial remainder stays below the divisor, so 33 bits hold the shift and the
        // borrow lands in the top bit of the difference
        rem_sh_c   = {hi_q, lo_q[XLEN-1]};
        div_diff_c = rem_sh_c - {1'b0, opb_q};
        div_ge_c   = !div_diff_c[XLEN];
        div_hi_c   = div_ge_c ? div_diff_c[XLEN-1:0] : rem_sh_c[XLEN-1:0];
        div_lo_c   = {lo_q[XLEN-2:0], div_ge_c};

        prod_c     = {mul_hi_c, mul_lo_c};
        if (neg_q) begin
            prod_c = DW'(0) - prod_c;
        end
        div_sel_c  = op_q[1] ? div_hi_c : div_lo_c;
        div_res_c  = neg_q ? (XLEN'(0) - div_sel_c) : div_sel_c;

        if (op_q[2]) begin
            calc_res_c = div_res_c;
        end else if (op_q == OP_MUL) begin
            calc_res_c = prod_c[XLEN-1:0];
        end else begin
            calc_res_c = prod_c[DW-1:XLEN];
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            opb_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            opb_q    <= opb_d;
            result_q <= result_d;
        end
    end

    // Next-state logic; a flush wins over everything
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (issue_c) begin
                    state_d = (div_zero_c || div_ovf_c) ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (md_kill) begin
            state_d = S_IDLE;
        end
    end

    // Datapath next values
    always_comb begin
        cnt_d    = cnt_q;
        op_d     = op_q;
        neg_d    = neg_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        opb_d    = opb_q;
        result_d = result_q;
        if (md_kill) begin
            cnt_d = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (issue_c) begin
                        op_d  = md_op;
                        cnt_d = '0;
                        if (div_zero_c) begin
                            result_d = md_op[1] ? md_rs1 : ALL_ONES;
                        end else if (div_ovf_c) begin
                            result_d = md_op[1] ? '0 : INT_MIN;
                        end else begin
                            hi_d  = '0;
                            lo_d  = mag_a_c;
                            opb_d = mag_b_c;
                            // REM follows the dividend; all others follow the sign product
                            neg_d = (md_op == OP_REM) ? a_neg_c : (a_neg_c ^ b_neg_c);
                        end
                    end
                end
                S_CALC: begin
                    hi_d  = op_q[2] ? div_hi_c : mul_hi_c;
                    lo_d  = op_q[2] ? div_lo_c : mul_lo_c;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        cnt_d    = '0;
                        result_d = calc_res_c;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs: stall is combinational on the issue cycle, the rest decode registered state
    always_comb begin
        md_stall  = !rst && (issue_c || (state_q == S_CALC));
        md_done   = (state_q == S_DONE);
        md_busy   = (state_q == S_CALC);
        md_result = result_q;
    end

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Self-checking bench for ex_muldiv_seq: directed RV32M cases, divide corner cases,
// flush and asynchronous reset behaviour, and random ops against a plain-arithmetic model.
module tb_ex_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        md_start;
    logic [2:0]  md_op;
    logic [31:0] md_rs1, md_rs2;
    logic        md_kill;
    logic        md_stall, md_done, md_busy;
    logic [31:0] md_result;

    int total = 0;
    int bad   = 0;

    ex_muldiv_seq #(.XLEN(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .md_start  (md_start),
        .md_op     (md_op),
        .md_rs1    (md_rs1),
        .md_rs2    (md_rs2),
        .md_kill   (md_kill),
        .md_stall  (md_stall),
        .md_done   (md_done),
        .md_result (md_result),
        .md_busy   (md_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // RV32M semantics straight from the ISA rules using 64-bit and native signed arithmetic
    function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        logic signed [63:0] sa, sb, ua, ub, p;
        logic [31:0] int_min;
        int_min = 32'h8000_0000;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        ref_md = '0;
        case (op)
            3'd0: begin p = sa * sb; ref_md = p[31:0];  end
            3'd1: begin p = sa * sb; ref_md = p[63:32]; end
            3'd2: begin p = sa * ub; ref_md = p[63:32]; end
            3'd3: begin p = ua * ub; ref_md = p[63:32]; end
            3'd4: begin
                if (b == 0) ref_md = 32'hFFFF_FFFF;
                else if (a == int_min && b == 32'hFFFF_FFFF) ref_md = int_min;
                else ref_md = 32'($signed(a) / $signed(b));
            end
            3'd5: ref_md = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) ref_md = a;
                else if (a == int_min && b == 32'hFFFF_FFFF) ref_md = 32'd0;
                else ref_md = 32'($signed(a) % $signed(b));
            end
            default: ref_md = (b == 0) ? a : a % b;
        endcase
    endfunction

    // Issue one op in the current cycle (called just after a rising edge) and follow it
    // to completion; latency is counted in cycles from the issue cycle.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int stall_n = 0;
        int done_at = -1;
        md_op = op; md_rs1 = a; md_rs2 = b; md_start = 1'b1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (md_stall) stall_n++;
            if (md_done && done_at < 0) begin
                done_at = k;
                chk({tag, " result"}, md_result, exp);
            end
            @(posedge clk); #1;
            if (done_at >= 0) break;
        end
        md_start = 1'b0;
        chk({tag, " done_cycle"}, 32'(done_at), 32'(exp_lat));
        chk({tag, " stall_cycles"}, 32'(stall_n), 32'(exp_lat));
        @(negedge clk);
        chk({tag, " done_single"}, 32'(md_done), 32'd0);
        chk({tag, " result_hold"}, md_result, exp);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra, rb, prior;
        logic        saw_done;
        int          lat;

        rst = 1'b1; md_start = 1'b0; md_op = '0; md_rs1 = '0; md_rs2 = '0; md_kill = 1'b0;
        #12;
        chk("reset stall",  32'(md_stall), 32'd0);
        chk("reset done",   32'(md_done),  32'd0);
        chk("reset busy",   32'(md_busy),  32'd0);
        chk("reset result", md_result,     32'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // Directed multiply / divide cases
        run_op("mul",    3'd0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
        run_op("mulh",   3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
        run_op("mulhu",  3'd3, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
        run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
        run_op("div",    3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33);
        run_op("rem",    3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33);
        run_op("divu",   3'd5, 32'd100,       32'd7,         32'd14,        33);
        run_op("remu",   3'd7, 32'd100,       32'd7,         32'd2,         33);

        // Divide corner cases complete in one cycle
        run_op("divu_by0", 3'd5, 32'h1234_5678, 32'd0,         32'hFFFF_FFFF, 1);
        run_op("rem_by0",  3'd6, 32'd5,         32'd0,         32'd5,         1);
        run_op("div_ovf",  3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("rem_ovf",  3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);

        // Flush in the middle of a divide
        prior = 32'd0;
        saw_done = 1'b0;
        md_op = 3'd4; md_rs1 = 32'd1000; md_rs2 = 32'd3; md_start = 1'b1;
        for (int k = 0; k <= 10; k++) begin
            if (k == 10) md_kill = 1'b1;
            @(negedge clk);
            if (md_done) saw_done = 1'b1;
            @(posedge clk); #1;
        end
        md_kill = 1'b0;
        chk("kill idle",      32'(md_busy),  32'd0);
        chk("kill no_done",   32'(saw_done), 32'd0);
        chk("kill result",    md_result,     prior);
        run_op("mul_after_kill", 3'd0, 32'd3, 32'd4, 32'd12, 33);

        // Asynchronous reset between edges mid-iteration
        md_op = 3'd0; md_rs1 = 32'd123; md_rs2 = 32'd456; md_start = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
        end
        chk("pre_rst busy", 32'(md_busy), 32'd1);
        @(negedge clk); #2;
        rst = 1'b1; md_start = 1'b0;
        #1;
        chk("rst busy",   32'(md_busy),  32'd0);
        chk("rst done",   32'(md_done),  32'd0);
        chk("rst stall",  32'(md_stall), 32'd0);
        chk("rst result", md_result,     32'd0);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst idle", 32'(md_busy), 32'd0);
        run_op("mulhu_after_rst", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);

        // Random ops against the reference model, with a bias toward divide corners
        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(7, 0));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(7, 0))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(9, 1));
                3: ra = 32'($urandom_range(100, 0));
                default: ;
            endcase
            lat = 33;
            if (rop[2] && (rb == 32'd0)) lat = 1;
            if ((rop == 3'd4 || rop == 3'd6) && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF)
                lat = 1;
            run_op($sformatf("rand%0d op%0d", i, rop), rop, ra, rb, ref_md(rop, ra, rb), lat);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
